// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO access controller: FSM states and arbitration source IDs.
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_RELEASE,
        RD_STROBE,
        RD_RELEASE,
        RD_CAPTURE
    } state_t;

    typedef enum logic [1:0] {
        SRC_W0 = 2'd0,
        SRC_W1 = 2'd1,
        SRC_R  = 2'd2
    } src_t;

    localparam int unsigned NUM_SRC = 3;

    // Pointer value that follows a one-hot grant (rotates W0 -> W1 -> R -> W0).
    function automatic src_t next_src(input logic [NUM_SRC-1:0] grant);
        if (grant[0])      return SRC_W1;
        else if (grant[1]) return SRC_R;
        else               return SRC_W0;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant, pointer advances past the winner on accept.
module rr_arbiter3
    import fifo_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               accept,
    output logic [NUM_SRC-1:0] grant
);

    src_t ptr;

    always_comb begin
        grant = '0;
        unique case (ptr)
            SRC_W0: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
            SRC_W1: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            default: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SRC_W0;
        end else if (accept && (|grant)) begin
            ptr <= next_src(grant);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequences two writers and one reader onto a single-ported FIFO with round-robin access,
// stretched strobes and a running fill level.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned log2_addr  = 3
) (
    input  logic                  clk_i,
    input  logic                  n_reset_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [data_width-1:0] data0_i,
    input  logic [data_width-1:0] data1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    input  logic                  rd_req_i,
    output logic [data_width-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic [data_width-1:0] fifo_data_o,
    output logic                  fifo_wr_o,
    output logic                  fifo_rd_o,
    input  logic [data_width-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_full_i,
    output logic [log2_addr:0]    level_o,
    output logic                  busy_o
);

    localparam int unsigned depth = 1 << log2_addr;
    localparam logic [log2_addr:0] level_max = depth[log2_addr:0];

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] grant;
    logic               accept;
    logic               wr_w1;

    // Full/empty only matter while IDLE; the arbiter is only accepted there.
    assign elig = {rd_req_i & ~fifo_empty_i, req1_i & ~fifo_full_i, req0_i & ~fifo_full_i};

    rr_arbiter3 u_arb (
        .clk    (clk_i),
        .rst_n  (n_reset_i),
        .req    (elig),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant[SRC_R]) begin
                    state_nxt = RD_STROBE;
                    accept    = 1'b1;
                end else if (grant[SRC_W0] || grant[SRC_W1]) begin
                    state_nxt = WR_SETUP;
                    accept    = 1'b1;
                end
            end
            WR_SETUP:   state_nxt = WR_STROBE;
            WR_STROBE:  state_nxt = WR_RELEASE;
            WR_RELEASE: state_nxt = IDLE;
            RD_STROBE:  state_nxt = RD_RELEASE;
            RD_RELEASE: state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Strobes and pulses are registered from the next state so they align with the state itself.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state       <= IDLE;
            wr_w1       <= 1'b0;
            fifo_data_o <= '0;
            fifo_wr_o   <= 1'b0;
            fifo_rd_o   <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            level_o     <= '0;
        end else begin
            state      <= state_nxt;
            fifo_wr_o  <= (state_nxt == WR_STROBE);
            fifo_rd_o  <= (state_nxt == RD_STROBE);
            ack0_o     <= (state_nxt == WR_RELEASE) && !wr_w1;
            ack1_o     <= (state_nxt == WR_RELEASE) && wr_w1;
            rd_valid_o <= (state_nxt == RD_CAPTURE);

            if (state == IDLE) begin
                if (grant[SRC_W0]) begin
                    fifo_data_o <= data0_i;
                    wr_w1       <= 1'b0;
                end else if (grant[SRC_W1]) begin
                    fifo_data_o <= data1_i;
                    wr_w1       <= 1'b1;
                end
            end

            if (state_nxt == RD_CAPTURE) begin
                rd_data_o <= fifo_data_i;
            end

            if (state == WR_STROBE && level_o != level_max) begin
                level_o <= level_o + 1'b1;
            end else if (state == RD_RELEASE && level_o != '0) begin
                level_o <= level_o - 1'b1;
            end
        end
    end

    assign busy_o = (state != IDLE);

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!n_reset_i)
        !(state == WR_STROBE && level_o == level_max));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!n_reset_i)
        !(state == RD_RELEASE && level_o == '0));
    a_strobe_excl : assert property (@(posedge clk_i) disable iff (!n_reset_i)
        !(fifo_wr_o && fifo_rd_o));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based transaction model plus an attached behavioural FIFO.
module tb_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned LA    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          req0, req1, rd_req;
    logic [DW-1:0] data0, data1;
    logic          ack0, ack1, rd_valid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] fifo_wdata, fifo_rdata;
    logic          fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [LA:0]   level;
    logic          busy;

    always #5 clk = ~clk;

    fifo_ctrl #(.data_width(DW), .log2_addr(LA)) dut (
        .clk_i        (clk),
        .n_reset_i    (n_reset),
        .req0_i       (req0),
        .req1_i       (req1),
        .data0_i      (data0),
        .data1_i      (data1),
        .ack0_o       (ack0),
        .ack1_o       (ack1),
        .rd_req_i     (rd_req),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .fifo_data_o  (fifo_wdata),
        .fifo_wr_o    (fifo_wr),
        .fifo_rd_o    (fifo_rd),
        .fifo_data_i  (fifo_rdata),
        .fifo_empty_i (fifo_empty),
        .fifo_full_i  (fifo_full),
        .level_o      (level),
        .busy_o       (busy)
    );

    // Attached FIFO: registered read data, shares the controller reset.
    logic [DW-1:0] mem [DEPTH];
    int unsigned   wp, rp, cnt;
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wp <= 0; rp <= 0; cnt <= 0; fifo_rdata <= '0;
        end else begin
            if (fifo_wr && cnt < DEPTH) begin
                mem[wp] <= fifo_wdata;
                wp <= (wp + 1) % DEPTH;
            end
            if (fifo_rd && cnt > 0) begin
                fifo_rdata <= mem[rp];
                rp <= (rp + 1) % DEPTH;
            end
            cnt <= cnt + ((fifo_wr && cnt < DEPTH) ? 1 : 0) - ((fifo_rd && cnt > 0) ? 1 : 0);
        end
    end
    assign fifo_empty = (cnt == 0);
    assign fifo_full  = (cnt == DEPTH);

    // Reference model: op = granted source (0/1 write, 2 read), ph = cycles since grant (0 = idle).
    int            ph, op, ptr;
    logic [DW-1:0] ref_q [$];
    logic [DW-1:0] wdata, exp_rdata;
    int            w_left0, w_left1, r_left;
    int            obs_q [$];
    int            passed = 0, failed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; op = 0; ptr = 0; exp_rdata = '0; wdata = '0;
        ref_q.delete();
    endtask

    task automatic model_update();
        logic [2:0] elig;
        int c;
        if (ph == 0) begin
            elig[0] = req0 && (ref_q.size() < DEPTH);
            elig[1] = req1 && (ref_q.size() < DEPTH);
            elig[2] = rd_req && (ref_q.size() > 0);
            for (int k = 0; k < 3; k++) begin
                c = (ptr + k) % 3;
                if (ph == 0 && elig[c]) begin
                    op = c; ptr = (c + 1) % 3; ph = 1;
                    wdata = (c == 1) ? data1 : data0;
                end
            end
        end else begin
            ph = (ph + 1) % 4;
            if (ph == 3) begin
                if (op < 2) ref_q.push_back(wdata);
                else        exp_rdata = ref_q.pop_front();
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy",     busy,     ph != 0);
        chk("fifo_wr",  fifo_wr,  op < 2 && ph == 2);
        chk("fifo_rd",  fifo_rd,  op == 2 && ph == 1);
        chk("ack0",     ack0,     op == 0 && ph == 3);
        chk("ack1",     ack1,     op == 1 && ph == 3);
        chk("rd_valid", rd_valid, op == 2 && ph == 3);
        chk("level",    level,    ref_q.size());
        chk("rd_data",  rd_data,  exp_rdata);
        if (ack0)     obs_q.push_back(0);
        if (ack1)     obs_q.push_back(1);
        if (rd_valid) obs_q.push_back(2);
    endtask

    task automatic set_reqs();
        req0   = (w_left0 > 0);
        req1   = (w_left1 > 0);
        rd_req = (r_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_reset) model_update();
        @(negedge clk);
        check_outputs();
        if (ph == 3 && op == 0) begin w_left0--; data0 = DW'($urandom); end
        if (ph == 3 && op == 1) begin w_left1--; data1 = DW'($urandom); end
        if (ph == 3 && op == 2) r_left--;
        set_reqs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_quiet(input string tag, input int max);
        int i = 0;
        while ((w_left0 > 0 || w_left1 > 0 || r_left > 0 || ph != 0) && i < max) begin
            tick();
            i++;
        end
        chk(tag, i < max, 1'b1);
    endtask

    initial begin
        n_reset = 1'b0;
        req0 = 0; req1 = 0; rd_req = 0; data0 = '0; data1 = '0;
        w_left0 = 0; w_left1 = 0; r_left = 0;
        model_reset();
        #1 check_outputs();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        // Single write of A5
        data0 = 8'hA5; w_left0 = 1; set_reqs();
        run_quiet("single_write_timeout", 20);
        chk("single_level", level, 1);
        chk("fifo_holds_a5", mem[rp], 8'hA5);

        r_left = 1; set_reqs();
        run_quiet("read_a5_timeout", 20);
        chk("read_a5", rd_data, 8'hA5);

        // Contention: 4 words each, acks must alternate
        obs_q.delete();
        data0 = 8'h11; data1 = 8'h22; w_left0 = 4; w_left1 = 4; set_reqs();
        run_quiet("contention_timeout", 100);
        for (int i = 0; i < 8; i++) chk("contention_order", obs_q[i], i % 2);
        chk("contention_full", fifo_full, 1'b1);

        // Full: 9th write stays pending until a read frees a slot
        w_left0 = 1; set_reqs();
        run(10);
        chk("full_pending_idle", busy, 1'b0);
        chk("full_pending_req", w_left0, 1);
        r_left = 1; set_reqs();
        run_quiet("full_timeout", 40);
        chk("full_level_after", level, 8);

        r_left = 8; set_reqs();
        run_quiet("drain_timeout", 200);
        chk("drain_level", level, 0);

        // Empty: read waits for a write of 3C
        r_left = 1; set_reqs();
        run(8);
        chk("empty_pending_idle", busy, 1'b0);
        data0 = 8'h3C; w_left0 = 1; set_reqs();
        run_quiet("empty_timeout", 40);
        chk("empty_rd_data", rd_data, 8'h3C);
        chk("empty_level", level, 0);

        // Mixed at level 4: five writes then one read leaves pointer at W0
        w_left0 = 5; set_reqs();
        run_quiet("preload_timeout", 60);
        r_left = 1; set_reqs();
        run_quiet("preload_rd_timeout", 20);
        obs_q.delete();
        w_left0 = 3; w_left1 = 3; r_left = 3; set_reqs();
        run_quiet("mixed_timeout", 100);
        for (int i = 0; i < 9; i++) chk("mixed_order", obs_q[i], i % 3);

        // Reset during WR_STROBE
        begin
            int i = 0;
            w_left0 = 1; set_reqs();
            while (!(ph == 2 && op == 0) && i < 20) begin tick(); i++; end
            chk("reach_wr_strobe", i < 20, 1'b1);
        end
        #2 n_reset = 1'b0;
        model_reset();
        w_left0 = 0; w_left1 = 0; r_left = 0; set_reqs();
        #1;
        chk("rst_fifo_wr", fifo_wr, 1'b0);
        chk("rst_ack0",    ack0,    1'b0);
        chk("rst_level",   level,   0);
        chk("rst_busy",    busy,    1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        run(6);

        // Random traffic
        repeat (600) begin
            if (w_left0 == 0 && $urandom_range(3) == 0) begin w_left0 = 1; data0 = DW'($urandom); end
            if (w_left1 == 0 && $urandom_range(3) == 0) begin w_left1 = 1; data1 = DW'($urandom); end
            if (r_left == 0 && $urandom_range(2) == 0) r_left = 1;
            set_reqs();
            tick();
        end
        begin
            int i = 0;
            while ((w_left0 > 0 || w_left1 > 0 || r_left > 0 || ph != 0) && i < 400) begin
                if (ph == 0 && ref_q.size() == DEPTH && r_left == 0) r_left = 1;
                if (ph == 0 && ref_q.size() == 0 && w_left0 == 0 && w_left1 == 0) r_left = 0;
                set_reqs();
                tick();
                i++;
            end
            chk("random_settle", i < 400, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
